multiplier: RTL
===============

# multiplier

Sequential unsigned shift-add multiplier for the multi-cycle MIPS datapath. It is the companion to the existing `divider` and uses the same start/done handshake. It accepts two DATA_WIDTH-bit operands and produces a 2×DATA_WIDTH-bit product split into hi/lo halves, which feed the HI/LO registers for `mult`/`multu`-class instructions. One product bit is retired per clock.

## Interface
- DATA_WIDTH, 32, operand width; product is 2×DATA_WIDTH (benches use 6)
- CLK  input  1  clock, rising-edge active
- RST  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- Operand1  input  DATA_WIDTH  multiplicand, captured on accepted start
- Operand2  input  DATA_WIDTH  multiplier, captured on accepted start
- result_hi  output  DATA_WIDTH  upper half of the last completed product
- result_lo  output  DATA_WIDTH  lower half of the last completed product
- done  output  1  one-cycle pulse when result_hi/result_lo update
- busy  output  1  high in RUN and DONE; start is ignored while high

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - With start=1 at the edge: capture Operand1 into the multiplicand register (2×DATA_WIDTH, zero-extended) and Operand2 into the multiplier register.
  - Clear the accumulator and the bit counter, then go to RUN.
  - With start=0: stay in IDLE.
- **RUN**, on each edge:
  - If multiplier[0]=1, add the multiplicand to the accumulator. The addition is 2×DATA_WIDTH wide and cannot overflow.
  - Shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
  - When counter==DATA_WIDTH-1 on this edge, go to DONE and load result_hi/result_lo from the final accumulator value.
- **DONE**
  - done=1 for exactly one cycle.
  - Unconditionally return to IDLE on the next edge.
  - A start asserted during DONE is ignored and is not queued.
- Outputs hold the last product until the next completion. A new accepted start does not clear result_hi/result_lo.
- Operand changes after the accepting edge have no effect.
- Reset values (on RST=0, at any time including mid-operation):
  - state=IDLE; result_hi=0, result_lo=0, done=0, busy=0.
  - All internal registers are 0.
  - The in-flight operation is discarded, and no done pulse is produced after RST is released.

## Timing
- Count the edge that accepts start as edge 1. RUN spans edges 2..DATA_WIDTH+1.
- done and the new result are visible after edge DATA_WIDTH+1 and remain valid through edge DATA_WIDTH+2, when the FSM returns to IDLE.
- Latency from start acceptance to done: DATA_WIDTH+1 cycles. With DATA_WIDTH=6 this is 7 cycles.
- Throughput: one operation every DATA_WIDTH+2 cycles. The earliest next start is accepted at the edge after done falls, i.e. while in IDLE.
- busy is high after edge 1 and falls after edge DATA_WIDTH+2.
- Operand2=0 still runs the full latency unless early termination is enabled.

## Configuration
- Macro: MULTIPLIER_EARLY_TERM_EN.
- **Defined:** in RUN, also transition to DONE on any edge where the shifted multiplier becomes 0.
  - Latency becomes (index of Operand2's highest set bit)+2 cycles.
  - Operand2=0 completes after a single RUN edge, i.e. done after edge 2.
  - The product is identical to the non-terminating case.
- **Undefined:** fixed DATA_WIDTH+1 latency. No zero-detect logic is synthesized.

## Test plan
All scenarios use DATA_WIDTH=6, active-low reset pulse first, and stimulus driven on negedge.
- 21×7 (=147): start for 1 cycle → done pulses exactly once, after the 7th edge; result_hi=2, result_lo=19; busy falls the cycle after done.
- 63×63 (=3969): result_hi=62, result_lo=1. 0×45 and 45×0: result_hi=0, result_lo=0 (without the macro, done after edge 7).
- Re-assert start and change operands to 1×1 during RUN and DONE of a 21×7 operation → ignored; result stays 2/19. A fresh 1×1 start in IDLE then yields 0/1.
- Assert RST=0 at the 3rd RUN cycle of 21×7 → outputs immediately 0 and state IDLE; no done follows. A subsequent 3×5 yields 0/15.
- With MULTIPLIER_EARLY_TERM_EN defined:
  - 5×1: done after edge 2, result 0/5.
  - 5×4: done after edge 4, result 0/20.
  - 5×32: done after edge 7, result 2/32 (160).

Source files
------------

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier with a start/done handshake.
// Retires one multiplier bit per clock; the 2*DATA_WIDTH product is
// presented as result_hi/result_lo and held until the next completion.
// Optional feature: define MULTIPLIER_EARLY_TERM_EN to finish as soon as
// the remaining multiplier bits are all zero.
module multiplier #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state, state_next;
    logic [PROD_W-1:0]     mcand, mcand_next;
    logic [PROD_W-1:0]     acc, acc_next;
    logic [PROD_W-1:0]     acc_sum_c;
    logic [DATA_WIDTH-1:0] mplier, mplier_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [DATA_WIDTH-1:0] hi_next, lo_next;
    logic                  done_next, busy_next;
    logic                  last_c;

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
            result_hi <= '0;
            result_lo <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            mcand     <= mcand_next;
            acc       <= acc_next;
            mplier    <= mplier_next;
            count     <= count_next;
            result_hi <= hi_next;
            result_lo <= lo_next;
            done      <= done_next;
            busy      <= busy_next;
        end
    end

    // Next-state, datapath step and registered-output next values
    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        acc_next    = acc;
        mplier_next = mplier;
        count_next  = count;
        hi_next     = result_hi;
        lo_next     = result_lo;
        done_next   = 1'b0;
        busy_next   = busy;

        // Partial-product add; width 2*DATA_WIDTH so it never overflows
        acc_sum_c = acc + (mplier[0] ? mcand : '0);

`ifdef MULTIPLIER_EARLY_TERM_EN
        last_c = (count == CNT_W'(DATA_WIDTH - 1)) || ((mplier >> 1) == '0);
`else
        last_c = (count == CNT_W'(DATA_WIDTH - 1));
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    mcand_next  = PROD_W'(Operand1);
                    mplier_next = Operand2;
                    acc_next    = '0;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    state_next  = S_RUN;
                end
            end
            S_RUN: begin
                acc_next    = acc_sum_c;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                count_next  = count + CNT_W'(1);
                if (last_c) begin
                    hi_next    = acc_sum_c[PROD_W-1:DATA_WIDTH];
                    lo_next    = acc_sum_c[DATA_WIDTH-1:0];
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
